// File: rtl/decode_pkg.sv
// Shared types and constants for the instruction decode stage.
package decode_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] ir_t;

  // addi x0, x0, 0
  localparam ir_t NOP = 32'h0000_0013;

  // Next-PC source selected in execute; anything but PC_PLUS4_TGT redirects fetch.
  typedef enum logic [1:0] {
    PC_PLUS4_TGT = 2'd0,
    JAL_BXX_TGT  = 2'd1,
    JALR_TGT     = 2'd2,
    TRAP_TGT     = 2'd3
  } tgt_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // OP_NOP is zero so a cleared ID/EX register reads as an invalid NOP entry.
  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LUI    = 4'd1,
    OP_AUIPC  = 4'd2,
    OP_JAL    = 4'd3,
    OP_JALR   = 4'd4,
    OP_BRANCH = 4'd5,
    OP_LOAD   = 4'd6,
    OP_STORE  = 4'd7,
    OP_OPIMM  = 4'd8,
    OP_OP     = 4'd9,
    OP_SYSTEM = 4'd10
  } op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_t;

  typedef struct packed {
    logic        valid;
    pc_t         pc;
    op_t         op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
    logic        illegal;
  } id_ex_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REPLAY = 2'd1,
    FLUSH  = 2'd2
  } decode_state_t;

  // Instruction parked while a load-use bubble drains.
  typedef struct packed {
    ir_t  ir;
    pc_t  pc;
    logic misaligned;
  } hold_t;

  function automatic logic uses_rs1(op_t op);
    return op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};
  endfunction

  function automatic logic uses_rs2(op_t op);
    return op inside {OP_BRANCH, OP_STORE, OP_OP};
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch/execute-facing signals of the decode stage.
interface decode_if;
  import decode_pkg::*;

  pc_t         pc;
  ir_t         ir;
  logic        misaligned;
  tgt_t        ex_target;
  logic        bubble;
  tgt_t        target;
  logic        id_valid;
  pc_t         id_pc;
  op_t         id_op;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [31:0] id_imm;
  logic        id_illegal;

  // Decode stage side.
  modport master (
    input  pc, ir, misaligned, ex_target,
    output bubble, target, id_valid, id_pc, id_op, id_rs1, id_rs2, id_rd,
           id_funct3, id_funct7b5, id_imm, id_illegal
  );

  // Fetch / execute side.
  modport slave (
    output pc, ir, misaligned, ex_target,
    input  bubble, target, id_valid, id_pc, id_op, id_rs1, id_rs2, id_rd,
           id_funct3, id_funct7b5, id_imm, id_illegal
  );

endinterface

// File: rtl/decode_imm.sv
// Immediate extraction: picks the RISC-V immediate format and sign-extends it.
module decode_imm
  import decode_pkg::*;
(
  input  ir_t         ir,
  input  imm_sel_t    sel,
  output logic [31:0] imm
);

  logic unused_opcode;
  assign unused_opcode = ^ir[6:0];

  // Reassemble the scattered immediate bits for the selected format.
  always_comb begin
    imm = '0;
    unique case (sel)
      IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   imm = {ir[31:12], 12'b0};
      IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// Instruction decode stage: field split, ID/EX register, load-use stall and
// post-redirect squash for the front end.
module decode
  import decode_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic     clk,
  input  logic     resetn,
  decode_if.master bus
);

  // The redirect cycle itself squashes one instruction; FLUSH covers the rest.
  localparam logic [1:0] FlushLoad = 2'(FLUSH_CYCLES - 1);

  decode_state_t state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  hold_t         hold_q, hold_d;
  id_ex_t        id_q, id_d;

  ir_t  sel_ir;
  pc_t  sel_pc;
  logic sel_mis;

  // Replay decodes the parked instruction; every other state decodes fetch's output.
  always_comb begin
    sel_ir  = bus.ir;
    sel_pc  = bus.pc;
    sel_mis = bus.misaligned;
    if (state_q == REPLAY) begin
      sel_ir  = hold_q.ir;
      sel_pc  = hold_q.pc;
      sel_mis = hold_q.misaligned;
    end
  end

  op_t         op;
  imm_sel_t    imm_sel;
  logic        has_rd, has_imm, known;
  logic [31:0] imm;

  // Classify the opcode and choose the immediate format.
  always_comb begin
    op      = OP_NOP;
    imm_sel = IMM_I;
    has_rd  = 1'b0;
    has_imm = 1'b0;
    known   = 1'b1;
    case (sel_ir[6:0])
      OPC_LUI:    begin op = OP_LUI;    imm_sel = IMM_U; has_rd = 1'b1; has_imm = 1'b1; end
      OPC_AUIPC:  begin op = OP_AUIPC;  imm_sel = IMM_U; has_rd = 1'b1; has_imm = 1'b1; end
      OPC_JAL:    begin op = OP_JAL;    imm_sel = IMM_J; has_rd = 1'b1; has_imm = 1'b1; end
      OPC_JALR:   begin op = OP_JALR;   imm_sel = IMM_I; has_rd = 1'b1; has_imm = 1'b1; end
      OPC_BRANCH: begin op = OP_BRANCH; imm_sel = IMM_B; has_imm = 1'b1; end
      OPC_LOAD:   begin op = OP_LOAD;   imm_sel = IMM_I; has_rd = 1'b1; has_imm = 1'b1; end
      OPC_STORE:  begin op = OP_STORE;  imm_sel = IMM_S; has_imm = 1'b1; end
      OPC_OPIMM:  begin op = OP_OPIMM;  imm_sel = IMM_I; has_rd = 1'b1; has_imm = 1'b1; end
      OPC_OP:     begin op = OP_OP;     has_rd = 1'b1; end
      OPC_SYSTEM: begin op = OP_SYSTEM; imm_sel = IMM_I; has_rd = 1'b1; has_imm = 1'b1; end
      default:    known = 1'b0;
    endcase
  end

  decode_imm u_decode_imm (
    .ir  (sel_ir),
    .sel (imm_sel),
    .imm (imm)
  );

  id_ex_t dec;
  logic   illegal;

  // Build the valid entry; illegal instructions carry only pc, funct bits and the flag.
  always_comb begin
    illegal      = ~known | sel_mis;
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = sel_pc;
    dec.funct3   = sel_ir[14:12];
    dec.funct7b5 = sel_ir[30];
    dec.illegal  = illegal;
    if (!illegal) begin
      dec.op  = op;
      dec.rs1 = uses_rs1(op) ? sel_ir[19:15] : 5'd0;
      dec.rs2 = uses_rs2(op) ? sel_ir[24:20] : 5'd0;
      dec.rd  = has_rd ? sel_ir[11:7] : 5'd0;
      dec.imm = has_imm ? imm : 32'd0;
    end
  end

  logic redirect, hazard, bubble;

  assign redirect = (bus.ex_target != PC_PLUS4_TGT);
  // Load in ID/EX writes a register the incoming instruction reads.
  assign hazard = id_q.valid && (id_q.op == OP_LOAD) && (id_q.rd != 5'd0) &&
                  ((uses_rs1(dec.op) && (dec.rs1 == id_q.rd)) ||
                   (uses_rs2(dec.op) && (dec.rs2 == id_q.rd)));

  // Pipeline control: redirect beats hazard; invalid entries are all-zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    id_d    = '0;
    bubble  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          cnt_d   = FlushLoad;
          state_d = (FlushLoad == 2'd0) ? RUN : FLUSH;
        end else if (hazard) begin
          bubble  = 1'b1;
          hold_d  = '{ir: bus.ir, pc: bus.pc, misaligned: bus.misaligned};
          state_d = REPLAY;
        end else begin
          id_d = dec;
        end
      end
      REPLAY: begin
        if (redirect) begin
          hold_d  = '0;
          cnt_d   = FlushLoad;
          state_d = (FlushLoad == 2'd0) ? RUN : FLUSH;
        end else begin
          id_d    = dec;
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (redirect) begin
          cnt_d   = FlushLoad;
          state_d = (FlushLoad == 2'd0) ? RUN : FLUSH;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_d == 2'd0) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, hold and ID/EX registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      hold_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      id_q    <= id_d;
    end
  end

  assign bus.bubble      = bubble;
  assign bus.target      = bus.ex_target;
  assign bus.id_valid    = id_q.valid;
  assign bus.id_pc       = id_q.pc;
  assign bus.id_op       = id_q.op;
  assign bus.id_rs1      = id_q.rs1;
  assign bus.id_rs2      = id_q.rs2;
  assign bus.id_rd       = id_q.rd;
  assign bus.id_funct3   = id_q.funct3;
  assign bus.id_funct7b5 = id_q.funct7b5;
  assign bus.id_imm      = id_q.imm;
  assign bus.id_illegal  = id_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Bench for the decode stage: directed scenarios plus a randomized run
// against an instruction-level reference model.
module tb_decode;
  import decode_pkg::*;

  localparam int unsigned FlushCycles = 2;

  localparam ir_t ADDI_X1_5 = 32'h0050_0093; // addi x1,x0,5
  localparam ir_t ADDI_X5_7 = 32'h0070_0293; // addi x5,x0,7
  localparam ir_t LW_X3     = 32'h0001_2183; // lw x3,0(x2)
  localparam ir_t LW_X0     = 32'h0001_2003; // lw x0,0(x2)
  localparam ir_t ADD_X1    = 32'h0031_00B3; // add x1,x2,x3
  localparam ir_t BEQ_M4    = 32'hFE00_0EE3; // beq x0,x0,-4

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  decode_if bus ();

  decode #(.FLUSH_CYCLES(FlushCycles)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic id_ex_t mk(logic v, pc_t pc, op_t op, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic [2:0] f3, logic f7, logic [31:0] imm,
                                logic ill);
    id_ex_t e;
    e = '{valid: v, pc: pc, op: op, rs1: rs1, rs2: rs2, rd: rd, funct3: f3, funct7b5: f7,
          imm: imm, illegal: ill};
    return e;
  endfunction

  function automatic id_ex_t observed();
    id_ex_t e;
    e = '{valid: bus.id_valid, pc: bus.id_pc, op: bus.id_op, rs1: bus.id_rs1, rs2: bus.id_rs2,
          rd: bus.id_rd, funct3: bus.id_funct3, funct7b5: bus.id_funct7b5, imm: bus.id_imm,
          illegal: bus.id_illegal};
    return e;
  endfunction

  // Reference decode straight from the ISA field layout, immediates by arithmetic.
  function automatic id_ex_t ref_decode(ir_t ir, pc_t pc, logic mis);
    id_ex_t e;
    int sg, i_imm, s_imm, b_imm, j_imm, hi25;
    logic [31:0] u_imm;
    bit known;
    known = 1'b1;
    sg    = int'(ir) >>> 31;
    i_imm = int'(ir) >>> 20;
    hi25  = int'(ir) >>> 25;
    s_imm = hi25 * 32 + int'(ir[11:7]);
    b_imm = sg * 4096 + int'(ir[7]) * 2048 + int'(ir[30:25]) * 32 + int'(ir[11:8]) * 2;
    j_imm = sg * 1048576 + int'(ir[19:12]) * 4096 + int'(ir[20]) * 2048 + int'(ir[30:21]) * 2;
    u_imm = ir & 32'hFFFF_F000;
    e = '0;
    e.valid    = 1'b1;
    e.pc       = pc;
    e.funct3   = ir[14:12];
    e.funct7b5 = ir[30];
    case (ir[6:0])
      7'b0110111: begin e.op = OP_LUI;    e.rd = ir[11:7]; e.imm = u_imm; end
      7'b0010111: begin e.op = OP_AUIPC;  e.rd = ir[11:7]; e.imm = u_imm; end
      7'b1101111: begin e.op = OP_JAL;    e.rd = ir[11:7]; e.imm = j_imm; end
      7'b1100111: begin e.op = OP_JALR;   e.rd = ir[11:7]; e.rs1 = ir[19:15]; e.imm = i_imm; end
      7'b1100011: begin e.op = OP_BRANCH; e.rs1 = ir[19:15]; e.rs2 = ir[24:20]; e.imm = b_imm; end
      7'b0000011: begin e.op = OP_LOAD;   e.rd = ir[11:7]; e.rs1 = ir[19:15]; e.imm = i_imm; end
      7'b0100011: begin e.op = OP_STORE;  e.rs1 = ir[19:15]; e.rs2 = ir[24:20]; e.imm = s_imm; end
      7'b0010011: begin e.op = OP_OPIMM;  e.rd = ir[11:7]; e.rs1 = ir[19:15]; e.imm = i_imm; end
      7'b0110011: begin
        e.op = OP_OP; e.rd = ir[11:7]; e.rs1 = ir[19:15]; e.rs2 = ir[24:20];
      end
      7'b1110011: begin e.op = OP_SYSTEM; e.rd = ir[11:7]; e.imm = i_imm; end
      default:    known = 1'b0;
    endcase
    if (!known || mis) begin
      e.op = OP_NOP; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.imm = '0; e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(input ir_t ir, input pc_t pc, input logic mis, input tgt_t tgt);
    bus.ir         = ir;
    bus.pc         = pc;
    bus.misaligned = mis;
    bus.ex_target  = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    id_ex_t got, exp;
    resetn = 1'b0;
    drive(ADDI_X1_5, 32'h0, 1'b0, PC_PLUS4_TGT);
    tick();
    tick();
    got = observed();
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL reset_id: got %h want 0", got);
    end
    n_cmp++;
    if (bus.bubble !== 1'b0) begin
      n_err++; $display("FAIL reset_bubble: got %b want 0", bus.bubble);
    end
    resetn = 1'b1;
    tick();
    exp = mk(1'b1, 32'h0, OP_OPIMM, 5'd0, 5'd0, 5'd1, 3'd0, 1'b0, 32'd5, 1'b0);
    got = observed();
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_release_addi: got %h want %h", got, exp);
    end
  endtask

  task automatic test_load_use();
    id_ex_t got, exp;
    drive(LW_X3, 32'h100, 1'b0, PC_PLUS4_TGT);
    tick();
    drive(ADD_X1, 32'h104, 1'b0, PC_PLUS4_TGT);
    #1;
    n_cmp++;
    if (bus.bubble !== 1'b1) begin
      n_err++; $display("FAIL load_use_bubble: got %b want 1", bus.bubble);
    end
    tick();
    n_cmp++;
    if (bus.id_valid !== 1'b0 || bus.id_op !== OP_NOP || bus.id_rd !== 5'd0) begin
      n_err++; $display("FAIL load_use_invalid: got valid=%b op=%0d rd=%0d want 0/0/0",
                        bus.id_valid, bus.id_op, bus.id_rd);
    end
    drive(NOP, 32'h108, 1'b0, PC_PLUS4_TGT);
    #1;
    n_cmp++;
    if (bus.bubble !== 1'b0) begin
      n_err++; $display("FAIL load_use_bubble_once: got %b want 0", bus.bubble);
    end
    tick();
    exp = mk(1'b1, 32'h104, OP_OP, 5'd2, 5'd3, 5'd1, 3'd0, 1'b0, 32'd0, 1'b0);
    got = observed();
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL load_use_replay: got %h want %h", got, exp);
    end
  endtask

  task automatic test_load_x0();
    id_ex_t got, exp;
    drive(LW_X0, 32'h200, 1'b0, PC_PLUS4_TGT);
    tick();
    drive(ADD_X1, 32'h204, 1'b0, PC_PLUS4_TGT);
    #1;
    n_cmp++;
    if (bus.bubble !== 1'b0) begin
      n_err++; $display("FAIL load_x0_bubble: got %b want 0", bus.bubble);
    end
    tick();
    exp = mk(1'b1, 32'h204, OP_OP, 5'd2, 5'd3, 5'd1, 3'd0, 1'b0, 32'd0, 1'b0);
    got = observed();
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL load_x0_add: got %h want %h", got, exp);
    end
  endtask

  task automatic test_redirect();
    drive(ADDI_X1_5, 32'h300, 1'b0, PC_PLUS4_TGT);
    tick();
    drive(ADDI_X1_5, 32'h304, 1'b0, JAL_BXX_TGT);
    #1;
    n_cmp++;
    if (bus.target !== JAL_BXX_TGT) begin
      n_err++; $display("FAIL redirect_target: got %0d want %0d", bus.target, JAL_BXX_TGT);
    end
    tick();
    n_cmp++;
    if (bus.id_valid !== 1'b0) begin
      n_err++; $display("FAIL redirect_squash1: got valid=%b want 0", bus.id_valid);
    end
    drive(ADDI_X1_5, 32'h308, 1'b0, PC_PLUS4_TGT);
    tick();
    n_cmp++;
    if (bus.id_valid !== 1'b0) begin
      n_err++; $display("FAIL redirect_squash2: got valid=%b want 0", bus.id_valid);
    end
    drive(ADDI_X1_5, 32'h400, 1'b0, PC_PLUS4_TGT);
    tick();
    n_cmp++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h400) begin
      n_err++; $display("FAIL redirect_resume: got valid=%b pc=%h want 1/00000400",
                        bus.id_valid, bus.id_pc);
    end
  endtask

  task automatic test_redirect_hazard();
    id_ex_t got, exp;
    drive(LW_X3, 32'h500, 1'b0, PC_PLUS4_TGT);
    tick();
    drive(ADD_X1, 32'h504, 1'b0, JAL_BXX_TGT);
    #1;
    n_cmp++;
    if (bus.bubble !== 1'b0) begin
      n_err++; $display("FAIL redirect_hazard_bubble: got %b want 0", bus.bubble);
    end
    tick();
    drive(NOP, 32'h508, 1'b0, PC_PLUS4_TGT);
    tick();
    n_cmp++;
    if (bus.id_valid !== 1'b0) begin
      n_err++; $display("FAIL redirect_hazard_flush: got valid=%b want 0", bus.id_valid);
    end
    drive(ADDI_X5_7, 32'h600, 1'b0, PC_PLUS4_TGT);
    tick();
    exp = mk(1'b1, 32'h600, OP_OPIMM, 5'd0, 5'd0, 5'd5, 3'd0, 1'b0, 32'd7, 1'b0);
    got = observed();
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL redirect_hazard_no_replay: got %h want %h", got, exp);
    end
  endtask

  task automatic test_imm_illegal();
    id_ex_t got, exp;
    drive(BEQ_M4, 32'h700, 1'b0, PC_PLUS4_TGT);
    tick();
    exp = mk(1'b1, 32'h700, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    got = observed();
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL beq_imm: got %h want %h", got, exp);
    end
    drive(32'h0, 32'h702, 1'b1, PC_PLUS4_TGT);
    tick();
    exp = mk(1'b1, 32'h702, OP_NOP, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b1);
    got = observed();
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL misaligned_illegal: got %h want %h", got, exp);
    end
  endtask

  task automatic test_async_reset();
    id_ex_t got, exp;
    drive(ADDI_X1_5, 32'h800, 1'b0, PC_PLUS4_TGT);
    tick();
    #2 resetn = 1'b0;
    #1;
    got = observed();
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL async_reset_clear: got %h want 0", got);
    end
    #2 resetn = 1'b1;
    drive(LW_X3, 32'h900, 1'b0, PC_PLUS4_TGT);
    tick();
    drive(ADD_X1, 32'h904, 1'b0, PC_PLUS4_TGT);
    tick();
    #2 resetn = 1'b0;
    drive(ADDI_X5_7, 32'h908, 1'b0, PC_PLUS4_TGT);
    #3 resetn = 1'b1;
    tick();
    exp = mk(1'b1, 32'h908, OP_OPIMM, 5'd0, 5'd0, 5'd5, 3'd0, 1'b0, 32'd7, 1'b0);
    got = observed();
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL async_reset_replay_lost: got %h want %h", got, exp);
    end
  endtask

  task automatic test_random();
    id_ex_t prev, dec, nxt, got, held;
    bit     held_v, lu, redirect, exp_bubble;
    int     squash;
    ir_t    ir;
    pc_t    pc;
    logic   mis;
    tgt_t   tgt;
    resetn = 1'b0;
    drive(NOP, 32'h0, 1'b0, PC_PLUS4_TGT);
    tick();
    resetn = 1'b1;
    prev   = '0;
    held   = '0;
    held_v = 1'b0;
    squash = 0;
    for (int i = 0; i < 400; i++) begin
      ir = $urandom;
      case ($urandom_range(0, 12))
        0:       ir[6:0] = 7'b0110111;
        1:       ir[6:0] = 7'b0010111;
        2:       ir[6:0] = 7'b1101111;
        3:       ir[6:0] = 7'b1100111;
        4:       ir[6:0] = 7'b1100011;
        5:       ir[6:0] = 7'b0100011;
        6:       ir[6:0] = 7'b0010011;
        7:       ir[6:0] = 7'b0110011;
        8:       ir[6:0] = 7'b1110011;
        9:       ir[6:0] = 7'b1111111;
        default: ir[6:0] = 7'b0000011;
      endcase
      ir[11:7]  = 5'($urandom_range(0, 3));
      ir[19:15] = 5'($urandom_range(0, 3));
      ir[24:20] = 5'($urandom_range(0, 3));
      pc        = $urandom;
      pc[1:0]   = 2'b00;
      mis       = ($urandom_range(0, 15) == 0);
      tgt       = ($urandom_range(0, 9) == 0) ? tgt_t'($urandom_range(1, 3)) : PC_PLUS4_TGT;
      drive(ir, pc, mis, tgt);
      #1;
      redirect   = (tgt != PC_PLUS4_TGT);
      dec        = ref_decode(ir, pc, mis);
      lu         = prev.valid && prev.op == OP_LOAD && prev.rd != 5'd0 &&
                   (dec.rs1 == prev.rd || dec.rs2 == prev.rd);
      exp_bubble = !redirect && squash == 0 && !held_v && lu;
      n_cmp++;
      if (bus.bubble !== exp_bubble) begin
        n_err++; $display("FAIL rand_bubble[%0d]: got %b want %b", i, bus.bubble, exp_bubble);
      end
      n_cmp++;
      if (bus.target !== tgt) begin
        n_err++; $display("FAIL rand_target[%0d]: got %0d want %0d", i, bus.target, tgt);
      end
      if (redirect) begin
        nxt    = '0;
        squash = int'(FlushCycles) - 1;
        held_v = 1'b0;
      end else if (squash > 0) begin
        nxt = '0;
        squash--;
      end else if (held_v) begin
        nxt    = held;
        held_v = 1'b0;
      end else if (lu) begin
        nxt    = '0;
        held   = dec;
        held_v = 1'b1;
      end else begin
        nxt = dec;
      end
      tick();
      got = observed();
      n_cmp++;
      if (got !== nxt) begin
        n_err++; $display("FAIL rand_entry[%0d]: got %h want %h", i, got, nxt);
      end
      prev = nxt;
    end
  endtask

  initial begin
    drive(NOP, 32'h0, 1'b0, PC_PLUS4_TGT);
    test_reset();
    test_load_use();
    test_load_x0();
    test_redirect();
    test_redirect_hazard();
    test_imm_illegal();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
